// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle scheduler: FSM states, obstacle kinds and gap width.
package obstacle_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_LOAD  = 3'd2,
      S_WAIT  = 3'd3,
      S_SPAWN = 3'd4
   } sched_state_t;

   typedef enum logic [1:0] {
      OBS_CACTUS_SMALL = 2'd0,
      OBS_CACTUS_LARGE = 2'd1,
      OBS_BIRD_LOW     = 2'd2,
      OBS_BIRD_HIGH    = 2'd3
   } obstacle_t;

   localparam int GAP_W = 8;

   // Entry is zero-extended by the caller; legal MIN_GAP keeps the sum below 256.
   function automatic logic [GAP_W-1:0] gap_of(input logic [GAP_W-1:0] min_gap,
                                              input logic [GAP_W-1:0] entry);
      return min_gap + entry;
   endfunction

endpackage

// File: rtl/obstacle_buffer.sv
// Random-batch storage with the current spawn index and last-entry detection.
module obstacle_buffer
   import obstacle_pkg::*;
#(
   parameter int NUM_LEN    = 4,
   parameter int RAND_COUNT = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          load,
   input  logic                          advance,
   input  logic                          clear,
   input  logic [NUM_LEN*RAND_COUNT-1:0] randoms,
   output obstacle_t                     kind,
   output logic [NUM_LEN-1:0]            entry_next,
   output logic                          last
);

   localparam int IDX_W = (RAND_COUNT > 1) ? $clog2(RAND_COUNT) : 1;

   logic [NUM_LEN*RAND_COUNT-1:0] data;
   logic [IDX_W-1:0]              index;
   logic [IDX_W-1:0]              index_nxt;

   assign last       = (index == IDX_W'(RAND_COUNT - 1));
   assign index_nxt  = last ? '0 : index + IDX_W'(1);
   assign kind       = obstacle_t'(data[index*NUM_LEN +: 2]);
   assign entry_next = data[index_nxt*NUM_LEN +: NUM_LEN];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data  <= '0;
         index <= '0;
      end else if (clear) begin
         data  <= '0;
         index <= '0;
      end else if (load) begin
         data  <= randoms;
         index <= '0;
      end else if (advance) begin
         index <= index_nxt;
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: requests random batches and spawns one obstacle per gap expiry.
// Optional macro SCHED_STATS_EN enables the saturating spawn_total counter.
module obstacle_scheduler
   import obstacle_pkg::*;
#(
   parameter int NUM_LEN    = 4,
   parameter int RAND_COUNT = 4,
   parameter int MIN_GAP    = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          tick,
   input  logic [NUM_LEN*RAND_COUNT-1:0] randoms,
   output logic                          rand_start,
   output logic                          spawn,
   output logic [1:0]                    spawn_type,
   output logic [15:0]                   spawn_total
);

   localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

   sched_state_t       state, state_d;
   logic [GAP_W-1:0]   gap, gap_d;
   logic               spawn_i;
   logic               buf_load, buf_adv, buf_clear;
   obstacle_t          kind;
   logic [NUM_LEN-1:0] entry_next;
   logic               last;

   obstacle_buffer #(
      .NUM_LEN   (NUM_LEN),
      .RAND_COUNT(RAND_COUNT)
   ) u_buffer (
      .clock     (clock),
      .reset     (reset),
      .load      (buf_load),
      .advance   (buf_adv),
      .clear     (buf_clear),
      .randoms   (randoms),
      .kind      (kind),
      .entry_next(entry_next),
      .last      (last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         gap   <= '0;
      end else begin
         state <= state_d;
         gap   <= gap_d;
      end
   end

   always_comb begin
      state_d    = state;
      gap_d      = gap;
      rand_start = 1'b0;
      spawn_i    = 1'b0;
      buf_load   = 1'b0;
      buf_adv    = 1'b0;
      buf_clear  = 1'b0;
      // Dropping run outranks everything else, including a coincident tick.
      if (state != S_IDLE && !run) begin
         state_d   = S_IDLE;
         gap_d     = '0;
         buf_clear = 1'b1;
      end else begin
         case (state)
            S_IDLE:  if (run) state_d = S_REQ;
            S_REQ: begin
               rand_start = 1'b1;
               state_d    = S_LOAD;
            end
            S_LOAD: begin
               buf_load = 1'b1;
               gap_d    = gap_of(MIN_GAP_V, GAP_W'(randoms[NUM_LEN-1:0]));
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               if (tick) begin
                  gap_d = gap - GAP_W'(1);
                  if (gap == GAP_W'(1)) state_d = S_SPAWN;
               end
            end
            S_SPAWN: begin
               spawn_i = 1'b1;
               if (last) begin
                  state_d = S_REQ;
               end else begin
                  buf_adv = 1'b1;
                  gap_d   = gap_of(MIN_GAP_V, GAP_W'(entry_next));
                  state_d = S_WAIT;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign spawn      = spawn_i;
   assign spawn_type = spawn_i ? kind : OBS_CACTUS_SMALL;

`ifdef SCHED_STATS_EN
   logic [15:0] total_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         total_q <= '0;
      else if (spawn_i && total_q != 16'hFFFF)
         total_q <= total_q + 16'd1;
   end

   assign spawn_total = total_q;
`else
   assign spawn_total = 16'h0000;
`endif

endmodule
